// File: rtl/ctrlr_poll_if.sv
// Read bus between the memory controller and the gamepad poller.
// The controller is the master: it drives the strobe and pad select and receives the data.
interface ctrlr_poll_if #(
    parameter int DATAWIDTH = 16
);
    logic                 ctrlr_re;
    logic [1:0]           addr_ctrlr;
    logic [DATAWIDTH-1:0] dout;

    modport master (
        output ctrlr_re,
        output addr_ctrlr,
        input  dout
    );

    modport slave (
        input  ctrlr_re,
        input  addr_ctrlr,
        output dout
    );
endinterface

// File: rtl/ctrlr_poll.sv
// Polls four NES-style serial pads once per frame over a shared latch/clock and
// serves one committed button byte per pad, with a per-pad "new since last read" flag.
module ctrlr_poll #(
    parameter int DATAWIDTH   = 16,
    parameter int CLK_DIV     = 150,
    parameter int POLL_PERIOD = 416667
) (
    input  logic         clk,
    input  logic         rst_n,
    ctrlr_poll_if.slave  bus,
    input  logic [3:0]   pad_data,
    output logic         pad_latch,
    output logic         pad_clk,
    output logic         poll_busy
);
    localparam int CNT_W = $clog2(POLL_PERIOD);
    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_PERIOD - 1);
    localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HALF_LAST  = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_CLK_HI = 3'd2,
        S_CLK_LO = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DIV_W-1:0]      r_div;
    logic [DIV_W-1:0]      w_div_nxt;
    logic [2:0]            r_bit_idx;
    logic [2:0]            w_idx_nxt;
    logic [CNT_W-1:0]      r_poll_cnt;
    logic [3:0]            r_sync1;
    logic [3:0]            r_sync2;
    logic [3:0][7:0]       r_shift;
    logic [3:0][7:0]       r_buttons;
    logic [3:0]            r_new;
    logic                  r_pad_latch;
    logic                  r_pad_clk;
    logic                  r_busy;
    logic                  w_sample;
    logic                  w_commit;
    logic [DATAWIDTH-1:0]  w_dout;

    // Two-flop synchronizer; idle level is high (released / disconnected pad).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= pad_data;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running frame timer; a frame may only start when it reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_poll_cnt <= '0;
        end else if (r_poll_cnt == POLL_LAST) begin
            r_poll_cnt <= '0;
        end else begin
            r_poll_cnt <= r_poll_cnt + CNT_W'(1);
        end
    end

    // State, divider, bit index and the registered pad-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_bit_idx   <= 3'd0;
            r_pad_latch <= 1'b0;
            r_pad_clk   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div       <= w_div_nxt;
            r_bit_idx   <= w_idx_nxt;
            r_pad_latch <= (w_state_nxt == S_LATCH);
            r_pad_clk   <= (w_state_nxt == S_CLK_HI);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    // Next-state logic; sampling happens on the last cycle of LATCH and of each CLK_LO.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div + DIV_W'(1);
        w_idx_nxt   = r_bit_idx;
        w_sample    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_div_nxt = '0;
                w_idx_nxt = 3'd0;
                if (r_poll_cnt == '0) begin
                    w_state_nxt = S_LATCH;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LATCH: begin
                if (r_div == LATCH_LAST) begin
                    w_sample    = 1'b1;
                    w_div_nxt   = '0;
                    w_idx_nxt   = 3'd1;
                    w_state_nxt = S_CLK_HI;
                end else begin
                    w_state_nxt = S_LATCH;
                end
            end
            S_CLK_HI: begin
                if (r_div == HALF_LAST) begin
                    w_div_nxt   = '0;
                    w_state_nxt = S_CLK_LO;
                end else begin
                    w_state_nxt = S_CLK_HI;
                end
            end
            S_CLK_LO: begin
                if (r_div == HALF_LAST) begin
                    w_sample  = 1'b1;
                    w_div_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_COMMIT;
                    end else begin
                        w_idx_nxt   = r_bit_idx + 3'd1;
                        w_state_nxt = S_CLK_HI;
                    end
                end else begin
                    w_state_nxt = S_CLK_LO;
                end
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_div_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_div_nxt   = '0;
                w_idx_nxt   = 3'd0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Shift registers fill bit by bit; button registers only move on COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_buttons <= '0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (w_sample) begin
                    r_shift[p][r_bit_idx] <= ~r_sync2[p];
                end else begin
                    r_shift[p][r_bit_idx] <= r_shift[p][r_bit_idx];
                end
            end
            if (w_commit) begin
                r_buttons <= r_shift;
            end else begin
                r_buttons <= r_buttons;
            end
        end
    end

    // New flags: COMMIT sets all four and beats a same-cycle read clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_new <= 4'h0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (w_commit) begin
                    r_new[p] <= 1'b1;
                end else if (bus.ctrlr_re && (bus.addr_ctrlr == 2'(p))) begin
                    r_new[p] <= 1'b0;
                end else begin
                    r_new[p] <= r_new[p];
                end
            end
        end
    end

    // Combinational read mux: flag in bit 15, buttons in the low byte.
    always_comb begin
        w_dout       = '0;
        w_dout[15]   = r_new[bus.addr_ctrlr];
        w_dout[7:0]  = r_buttons[bus.addr_ctrlr];
    end

    assign bus.dout  = w_dout;
    assign pad_latch = r_pad_latch;
    assign pad_clk   = r_pad_clk;
    assign poll_busy = r_busy;
endmodule

// File: tb/tb_ctrlr_poll.sv
// Directed bench for ctrlr_poll with CLK_DIV=4, POLL_PERIOD=100 and a shift-register
// model of four NES pads driving pad_data.
module tb_ctrlr_poll;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] pad_data;
    logic       pad_latch;
    logic       pad_clk;
    logic       poll_busy;
    logic [7:0] pad_btn [4];
    logic [3:0] pidx = 4'd0;
    int         n_checks = 0;
    int         n_pass = 0;

    ctrlr_poll_if #(.DATAWIDTH(16)) bus_if ();

    ctrlr_poll #(
        .DATAWIDTH  (16),
        .CLK_DIV    (4),
        .POLL_PERIOD(100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if.slave),
        .pad_data  (pad_data),
        .pad_latch (pad_latch),
        .pad_clk   (pad_clk),
        .poll_busy (poll_busy)
    );

    always #5 clk = ~clk;

    // Pad model: latch reloads to bit 0, each rising pad clock advances one bit.
    always @(posedge pad_clk or posedge pad_latch) begin
        if (pad_latch) pidx <= 4'd0;
        else           pidx <= pidx + 4'd1;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (pidx < 4'd8) pad_data[i] = ~pad_btn[i][pidx[2:0]];
            else             pad_data[i] = 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge after the first LATCH edge (cycle k=1 of a frame).
    task automatic wait_latch();
        int t;
        t = 0;
        while (!pad_latch && t < 250) begin
            @(negedge clk);
            t++;
        end
        check_eq("latch_timeout", {31'd0, pad_latch}, 32'd1);
    endtask

    // Called at the negedge where rst_n has just risen; checks cycles k=1..70.
    task automatic check_frame(input string tag);
        logic e_lat, e_clk, e_busy;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            e_lat  = (k >= 1) && (k <= 8);
            e_clk  = (k >= 9) && (k <= 64) && (((k - 9) % 8) < 4);
            e_busy = (k >= 1) && (k <= 65);
            check_eq(tag, {29'd0, pad_latch, pad_clk, poll_busy}, {29'd0, e_lat, e_clk, e_busy});
        end
    endtask

    task automatic read_pad(input logic [1:0] a, input string tag, input logic [15:0] exp);
        bus_if.addr_ctrlr = a;
        #1;
        check_eq(tag, {16'd0, bus_if.dout}, {16'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) pad_btn[i] = 8'h00;
        bus_if.ctrlr_re   = 1'b0;
        bus_if.addr_ctrlr = 2'd0;
        step(3);
        check_eq("rst_latch", {31'd0, pad_latch}, 32'd0);
        check_eq("rst_clk",   {31'd0, pad_clk},   32'd0);
        check_eq("rst_busy",  {31'd0, poll_busy}, 32'd0);
        read_pad(2'd0, "rst_dout", 16'h0000);

        // First frame right after reset release, all pads released.
        rst_n = 1'b1;
        check_frame("frame1_timing");
        for (int a = 0; a < 4; a++) read_pad(2'(a), "frame1_dout", 16'h8000);

        // Pad 2: A and Start pressed.
        pad_btn[2] = 8'h09;
        wait_latch();
        step(64);
        read_pad(2'd2, "pad2_precommit", 16'h8000);
        step(1);
        read_pad(2'd2, "pad2_commit", 16'h8009);
        read_pad(2'd0, "pad0_commit", 16'h8000);

        // Read strobe clears only the addressed flag.
        bus_if.addr_ctrlr = 2'd2;
        bus_if.ctrlr_re   = 1'b1;
        step(1);
        bus_if.ctrlr_re   = 1'b0;
        read_pad(2'd2, "pad2_cleared", 16'h0009);
        read_pad(2'd0, "pad0_kept", 16'h8000);
        read_pad(2'd3, "pad3_kept", 16'h8000);

        // Atomicity: pad 1 changes during CLK_HI of bit 4.
        wait_latch();
        step(32);
        pad_btn[1] = 8'hFF;
        bus_if.addr_ctrlr = 2'd1;
        for (int k = 34; k <= 65; k++) begin
            step(1);
            read_pad(2'd1, "pad1_hold", 16'h8000);
        end
        step(1);
        read_pad(2'd1, "pad1_commit", 16'h80F0);

        // Collision: read of pad 3 on the COMMIT cycle.
        pad_btn[3] = 8'h80;
        wait_latch();
        step(9);
        bus_if.addr_ctrlr = 2'd3;
        bus_if.ctrlr_re   = 1'b1;
        step(1);
        bus_if.ctrlr_re   = 1'b0;
        read_pad(2'd3, "pad3_clear", 16'h0000);
        step(54);
        check_eq("commit_busy", {31'd0, poll_busy}, 32'd1);
        bus_if.ctrlr_re = 1'b1;
        read_pad(2'd3, "collide_pre", 16'h0000);
        step(1);
        bus_if.ctrlr_re = 1'b0;
        read_pad(2'd3, "collide_post", 16'h8080);

        // Reset during CLK_HI of bit 4, pad 0 pressed only in the aborted frame.
        pad_btn[0] = 8'hFF;
        wait_latch();
        step(33);
        check_eq("abort_in_clk_hi", {31'd0, pad_clk}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_clk",   {31'd0, pad_clk},   32'd0);
        check_eq("abort_latch", {31'd0, pad_latch}, 32'd0);
        check_eq("abort_busy",  {31'd0, poll_busy}, 32'd0);
        read_pad(2'd0, "abort_dout0", 16'h0000);
        read_pad(2'd2, "abort_dout2", 16'h0000);
        pad_btn[0] = 8'h00;
        step(2);
        rst_n = 1'b1;
        check_frame("frame_after_abort");
        read_pad(2'd0, "after_abort0", 16'h8000);
        read_pad(2'd1, "after_abort1", 16'h80FF);
        read_pad(2'd2, "after_abort2", 16'h8009);
        read_pad(2'd3, "after_abort3", 16'h8080);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
